// File: rtl/riscv_pkg.sv
// Shared RV32I constants and the buffered fetch entry type used by the fetch stage.
package riscv_pkg;
  localparam int                 RV_XLEN     = 32;
  localparam logic [RV_XLEN-1:0] RV_NOP      = 32'h0000_0013;
  localparam logic [RV_XLEN-1:0] RV_RESET_PC = 32'h0000_0000;
  localparam logic [1:0]         ILEN_LSB_32 = 2'b11;

  typedef logic [RV_XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic logic is_illegal(input word_t w);
    return w[1:0] != ILEN_LSB_32;
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction memory req/gnt/rvalid, redirect from execute, decoder valid/ready.
interface instr_fetch_if;
  import riscv_pkg::*;

  logic  mem_req;
  word_t mem_addr;
  logic  mem_gnt;
  logic  mem_rvalid;
  word_t mem_rdata;
  logic  redirect_valid;
  word_t redirect_pc;
  word_t instr;
  word_t instr_pc;
  logic  instr_valid;
  logic  instr_illegal;
  logic  instr_ready;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid, instr_illegal,
    input  mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid, instr_illegal,
    output mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Buffer of {pc, instr}; head read straight from the storage flops, push/pop land on the next edge.
// No internal backpressure: the producer guarantees space, pop on empty is ignored, flush beats push.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int    DEPTH    = 2,
  parameter word_t RESET_PC = RV_RESET_PC
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  word_t                  push_pc,
  input  word_t                  push_instr,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output word_t                  head_pc,
  output word_t                  head_instr
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;

  assign do_pop     = pop && (count != '0);
  assign head_valid = (count != '0);
  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: RESET_PC, instr: RV_NOP};
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: one outstanding word read at a time, responses buffered with their PCs.
// Best case one request every 2 cycles; requests stop while buffer plus in-flight would overflow.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter word_t RESET_PC   = RV_RESET_PC,
  parameter int    FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           resetn,
  instr_fetch_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam int         CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int         OW     = CW + 1;
  localparam logic [OW-1:0] DEPTH_W = OW'(FIFO_DEPTH);

  logic [1:0]    state;
  word_t         fetch_pc;
  word_t         req_addr;
  logic          inflight;
  logic          kill;
  logic          pending;
  logic [CW-1:0] count;
  logic [OW-1:0] occupancy;
  logic          req;
  logic          push;
  logic          pop;
  word_t         head_instr;
  logic          head_valid;
  logic          unused_pc_lsbs;

  assign occupancy     = OW'(count) + OW'(inflight);
  assign req           = (state == S_REQ) && (pending || (occupancy < DEPTH_W));
  assign bus.mem_req   = req;
  assign bus.mem_addr  = pending ? req_addr : fetch_pc;
  assign push          = (state == S_WAIT) && inflight && bus.mem_rvalid && !kill && !bus.redirect_valid;
  assign pop           = head_valid && bus.instr_ready;
  assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

  assign bus.instr         = head_instr;
  assign bus.instr_valid   = head_valid;
  assign bus.instr_illegal = head_valid && is_illegal(head_instr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
      pending  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (req && bus.mem_gnt) begin
            state    <= S_WAIT;
            inflight <= 1'b1;
            pending  <= 1'b0;
            // A killed request was issued for the old stream; fetch_pc already holds the target.
            if (!kill) fetch_pc <= fetch_pc + 32'd4;
          end else if (req) begin
            pending <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            state    <= S_REQ;
            inflight <= 1'b0;
            kill     <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (req && !pending) req_addr <= fetch_pc;

      if (bus.redirect_valid) begin
        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        kill     <= req || (inflight && !bus.mem_rvalid);
      end
    end
  end

  fetch_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_pc    (req_addr),
    .push_instr (bus.mem_rdata),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .count      (count),
    .head_valid (head_valid),
    .head_pc    (bus.instr_pc),
    .head_instr (head_instr)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder plus scoreboard of expected {pc, instr} in delivery order.
module tb_instr_fetch;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  bit          mem_auto, gnt_hold, resp_stall;
  bit          have_resp, resp_dead, req_dead;
  logic [31:0] data_base, resp_addr;

  fetch_entry_t exp_q[$];
  logic [31:0]  gnt_log[$];
  logic [31:0]  pop_log[$];
  bit           pop_ill_log[$];
  int           gnt_cyc[$];

  logic        last_req, last_valid;
  logic [31:0] last_addr, last_instr, last_pc;

  function automatic logic [31:0] datafn(input logic [31:0] a);
    return data_base ^ {a[19:0], 12'h000};
  endfunction

  // One clock cycle: memory model, output sampling, scoreboard pop/flush/push.
  task automatic step();
    logic         rv, gnt, pop, redir, exp_ill;
    fetch_entry_t e;
    rv = have_resp && !resp_stall;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rv ? datafn(resp_addr) : 32'hDEAD_BEEF;
    #1;
    last_req  = bus.mem_req;
    last_addr = bus.mem_addr;
    gnt = mem_auto && !gnt_hold && bus.mem_req;
    bus.mem_gnt = gnt;
    #1;
    last_valid = bus.instr_valid;
    last_instr = bus.instr;
    last_pc    = bus.instr_pc;
    redir = bus.redirect_valid;
    pop   = bus.instr_valid && bus.instr_ready;
    if (pop) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h, scoreboard empty", bus.instr_pc, bus.instr);
      end else begin
        e = exp_q.pop_front();
        exp_ill = (e.instr[1:0] != 2'b11);
        if (bus.instr_pc !== e.pc || bus.instr !== e.instr || bus.instr_illegal !== exp_ill) begin
          n_err++;
          $display("FAIL pop_data: got pc=%h instr=%h ill=%b, want pc=%h instr=%h ill=%b",
                   bus.instr_pc, bus.instr, bus.instr_illegal, e.pc, e.instr, exp_ill);
        end
      end
      pop_log.push_back(bus.instr_pc);
      pop_ill_log.push_back(bus.instr_illegal);
    end
    if (redir) exp_q.delete();
    if (rv) begin
      if (!resp_dead && !redir) begin
        e.pc    = resp_addr;
        e.instr = datafn(resp_addr);
        exp_q.push_back(e);
      end
      have_resp = 1'b0;
    end else if (redir && have_resp) begin
      resp_dead = 1'b1;
    end
    if (redir && bus.mem_req) req_dead = 1'b1;
    if (gnt) begin
      gnt_log.push_back(bus.mem_addr);
      gnt_cyc.push_back(cyc);
      have_resp = 1'b1;
      resp_addr = bus.mem_addr;
      resp_dead = req_dead;
      req_dead  = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.mem_gnt = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    bus.mem_gnt        = 1'b0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = '0;
    mem_auto = 0; gnt_hold = 0; resp_stall = 0;
    have_resp = 0; resp_dead = 0; req_dead = 0;
    resp_addr = '0;
    data_base = 32'h0050_0093;
    exp_q.delete(); gnt_log.delete(); pop_log.delete(); pop_ill_log.delete(); gnt_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    n_cmp++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h0000_0013) begin n_err++; $display("FAIL rst_instr: got %h want 00000013", bus.instr); end
    n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_instr_pc: got %h want 0", bus.instr_pc); end
    n_cmp++; if (bus.instr_illegal !== 1'b0) begin n_err++; $display("FAIL rst_illegal: got %b want 0", bus.instr_illegal); end
    resetn = 1'b1;
    step();
    n_cmp++; if (last_req !== 1'b0) begin n_err++; $display("FAIL first_req_early: got %b want 0", last_req); end
    step();
    n_cmp++;
    if (last_req !== 1'b1 || last_addr !== 32'h0) begin
      n_err++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", last_req, last_addr);
    end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    mem_auto = 1; bus.instr_ready = 1'b1;
    resetn = 1'b1;
    step(); step(); step();
    n_cmp++; if (last_valid !== 1'b0) begin n_err++; $display("FAIL valid_early: got %b want 0", last_valid); end
    step();
    n_cmp++;
    if (last_valid !== 1'b1 || last_instr !== 32'h0050_0093 || last_pc !== 32'h0) begin
      n_err++; $display("FAIL first_instr: got v=%b instr=%h pc=%h want v=1 instr=00500093 pc=0", last_valid, last_instr, last_pc);
    end
    for (int i = 0; i < 20 && gnt_log.size() < 3; i++) step();
    n_cmp++;
    if (gnt_log.size() < 3) begin
      n_err++; $display("FAIL addr_seq: got %0d grants want 3", gnt_log.size());
    end else if (gnt_log[0] !== 32'h0 || gnt_log[1] !== 32'h4 || gnt_log[2] !== 32'h8) begin
      n_err++; $display("FAIL addr_seq: got %h %h %h want 0 4 8", gnt_log[0], gnt_log[1], gnt_log[2]);
    end
    n_cmp++;
    if (gnt_cyc.size() < 3 || gnt_cyc[1] - gnt_cyc[0] != 2 || gnt_cyc[2] - gnt_cyc[1] != 2) begin
      n_err++; $display("FAIL throughput: grant spacing not 2 cycles (%0d grants)", gnt_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_auto = 1;
    resetn = 1'b1;
    repeat (20) step();
    n_cmp++; if (gnt_log.size() != 2) begin n_err++; $display("FAIL bp_grants: got %0d want 2", gnt_log.size()); end
    n_cmp++; if (last_req !== 1'b0) begin n_err++; $display("FAIL bp_req_low: got %b want 0", last_req); end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 30 && (gnt_log.size() < 3 || pop_log.size() < 2); i++) step();
    n_cmp++;
    if (pop_log.size() < 2 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4) begin
      n_err++; $display("FAIL bp_pop_order: got %0d pops, want pcs 0 then 4", pop_log.size());
    end
    n_cmp++;
    if (gnt_log.size() < 3 || gnt_log[2] !== 32'h8) begin
      n_err++; $display("FAIL bp_resume: got %0d grants, want third at 8", gnt_log.size());
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_auto = 1;
    resetn = 1'b1;
    for (int i = 0; i < 20 && gnt_log.size() < 2; i++) step();
    resp_stall = 1;
    step(); step();
    n_cmp++;
    if (gnt_log.size() != 2 || last_valid !== 1'b1 || last_req !== 1'b0) begin
      n_err++; $display("FAIL rw_setup: got grants=%0d v=%b req=%b want 2 1 0", gnt_log.size(), last_valid, last_req);
    end
    bus.redirect_pc = 32'h0000_0103; bus.redirect_valid = 1'b1;
    step();
    resp_stall = 0;
    step();
    n_cmp++; if (last_valid !== 1'b0) begin n_err++; $display("FAIL rw_flush: got v=%b want 0", last_valid); end
    step();
    n_cmp++;
    if (last_req !== 1'b1 || last_addr !== 32'h100) begin
      n_err++; $display("FAIL rw_refetch: got req=%b addr=%h want req=1 addr=100", last_req, last_addr);
    end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 20 && pop_log.size() < 1; i++) step();
    n_cmp++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h100) begin
      n_err++; $display("FAIL rw_first_pc: got %0d pops, want first pc 100", pop_log.size());
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    mem_auto = 1; bus.instr_ready = 1'b1;
    resetn = 1'b1;
    for (int i = 0; i < 10 && gnt_log.size() < 1; i++) step();
    bus.redirect_pc = 32'h0000_0200; bus.redirect_valid = 1'b1;
    step();
    step();
    n_cmp++; if (last_valid !== 1'b0) begin n_err++; $display("FAIL rr_discard: got v=%b pc=%h want v=0", last_valid, last_pc); end
    n_cmp++;
    if (last_req !== 1'b1 || last_addr !== 32'h200) begin
      n_err++; $display("FAIL rr_refetch: got req=%b addr=%h want req=1 addr=200", last_req, last_addr);
    end
    for (int i = 0; i < 10 && pop_log.size() < 1; i++) step();
    n_cmp++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h200) begin
      n_err++; $display("FAIL rr_target_delivered: got %0d pops, want first pc 200", pop_log.size());
    end
  endtask

  task automatic test_gnt_stall_redirect();
    do_reset();
    mem_auto = 1; gnt_hold = 1; bus.instr_ready = 1'b1;
    resetn = 1'b1;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (last_req !== 1'b1 || last_addr !== 32'h0) begin
        n_err++; $display("FAIL gs_hold: got req=%b addr=%h want req=1 addr=0", last_req, last_addr);
      end
    end
    bus.redirect_pc = 32'h0000_0300; bus.redirect_valid = 1'b1;
    step();
    step();
    n_cmp++;
    if (last_req !== 1'b1 || last_addr !== 32'h0) begin
      n_err++; $display("FAIL gs_addr_stable: got req=%b addr=%h want req=1 addr=0", last_req, last_addr);
    end
    gnt_hold = 0;
    step(); step(); step();
    n_cmp++;
    if (last_req !== 1'b1 || last_addr !== 32'h300) begin
      n_err++; $display("FAIL gs_refetch: got req=%b addr=%h want req=1 addr=300", last_req, last_addr);
    end
    for (int i = 0; i < 10 && pop_log.size() < 1; i++) step();
    n_cmp++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h300) begin
      n_err++; $display("FAIL gs_first_pc: got %0d pops, want first pc 300", pop_log.size());
    end
  endtask

  task automatic test_illegal_wrap();
    do_reset();
    mem_auto = 1; bus.instr_ready = 1'b1; data_base = 32'h0;
    resetn = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF; bus.redirect_valid = 1'b1;
    step();
    for (int i = 0; i < 20 && gnt_log.size() < 2; i++) step();
    n_cmp++;
    if (gnt_log.size() < 2 || gnt_log[0] !== 32'hFFFF_FFFC || gnt_log[1] !== 32'h0) begin
      n_err++; $display("FAIL wrap_addr: got %0d grants, want FFFFFFFC then 0", gnt_log.size());
    end
    for (int i = 0; i < 20 && pop_log.size() < 2; i++) step();
    n_cmp++;
    if (pop_ill_log.size() < 2 || pop_ill_log[0] !== 1'b1 || pop_ill_log[1] !== 1'b1) begin
      n_err++; $display("FAIL illegal_flag: got %0d pops, want two with illegal=1", pop_ill_log.size());
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    mem_auto = 1;
    resetn = 1'b1;
    for (int i = 0; i < 20 && gnt_log.size() < 2; i++) step();
    resp_stall = 1;
    step();
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.mem_addr !== 32'h0) begin
      n_err++; $display("FAIL async_reset: got req=%b v=%b addr=%h want 0 0 0", bus.mem_req, bus.instr_valid, bus.mem_addr);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    resp_dead = 1; resp_stall = 0;
    exp_q.delete(); gnt_log.delete(); pop_log.delete(); pop_ill_log.delete();
    bus.instr_ready = 1'b1;
    step();
    step();
    n_cmp++;
    if (last_valid !== 1'b0 || last_req !== 1'b1 || last_addr !== 32'h0) begin
      n_err++; $display("FAIL stray_rvalid: got v=%b req=%b addr=%h want 0 1 0", last_valid, last_req, last_addr);
    end
    for (int i = 0; i < 10 && pop_log.size() < 1; i++) step();
    n_cmp++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h0) begin
      n_err++; $display("FAIL post_reset_fetch: got %0d pops, want first pc 0", pop_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_gnt_stall_redirect();
    test_illegal_wrap();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RV32I core, directly upstream of the instruction decoder. Maintains the fetch PC, issues one-at-a-time word reads to instruction memory over a req/gnt/rvalid interface, and buffers returned words with their PCs in a small FIFO. The FIFO drives the decoder through a valid/ready handshake. A redirect from execute (branch/jump) flushes all buffered and in-flight instructions and restarts fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, ≥2)
- clk  in  1  core clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- mem_req  out  1  read request; held high until mem_gnt
- mem_addr  out  32  request address; stable while mem_req high; bits [1:0] always 0
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; exactly one per granted request, ≥1 cycle after gnt
- mem_rdata  in  32  read data
- redirect_valid  in  1  single-cycle pulse: flush and refetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored
- instr  out  32  instruction at FIFO head
- instr_pc  out  32  PC of instr
- instr_valid  out  1  head entry valid
- instr_illegal  out  1  instr[1:0] != 2'b11 (not a 32-bit encoding); qualified by instr_valid
- instr_ready  in  1  decoder accepts head this cycle

## Operation
- States: IDLE (reset only), REQ, WAIT.
- IDLE -> REQ unconditionally on first clock edge with resetn high.
- REQ: mem_req high when count + inflight < FIFO_DEPTH, or when a request is already pending (once raised, mem_req never drops before gnt). Raising the request latches req_addr <= fetch_pc; mem_addr = req_addr.
- REQ, mem_req && mem_gnt: fetch_pc <= fetch_pc + 4 (wraps mod 2^32), inflight <= 1, -> WAIT.
- WAIT, mem_rvalid: if kill == 0, push {req_addr, mem_rdata}; if kill == 1, discard and clear kill; inflight <= 0; -> REQ.
- Pop when instr_valid && instr_ready.
- Push and pop in the same cycle are legal at any occupancy; the space check guarantees a push never overflows.
- Redirect (highest priority, any state):
  - count <= 0; instr_valid low next cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - kill <= 1 if a request is granted-but-unreturned or pending-without-gnt. A pending request keeps its old mem_addr until granted and is then discarded.
  - Redirect coinciding with mem_rvalid: that response is discarded and kill is not set.
  - Redirect coinciding with a pop: the decoder's acceptance of the old head stands; everything else is flushed.
- Width rules: PC arithmetic is 32-bit unsigned with no carry out. FIFO count is $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - mem_req 0; mem_addr RESET_PC.
  - instr_valid 0; instr 32'h0000_0013 (NOP); instr_pc RESET_PC; instr_illegal 0.
  - Internal: fetch_pc RESET_PC; count 0; inflight 0; kill 0; state IDLE.
- First mem_req is asserted in the second cycle after resetn deasserts.
- mem_rvalid (unkilled) -> instr_valid: 1 cycle; instr/instr_pc registered.
- Redirect at cycle N:
  - instr_valid low at N+1.
  - If idle, mem_req with mem_addr = redirect target at N+1.
  - If a request is outstanding, the target is requested in the cycle after the killed response.
- Peak throughput: one instruction per 2 cycles with 1-cycle memory (gnt same cycle, rvalid next).
- Reset asserted mid-operation: all state returns to reset values immediately. A later stray mem_rvalid is ignored because inflight is 0.

## Structure
- Shared package riscv_pkg: RV_XLEN = 32, RV_NOP = 32'h0000_0013, RV_RESET_PC, ILEN_LSB_32 = 2'b11.
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr}, depth FIFO_DEPTH, with push, pop, flush, count and registered head outputs.
- Top level holds the FSM, fetch_pc, req_addr, inflight and kill.

## Test plan
- Reset release, memory grants same cycle and returns next cycle with mem_rdata = 0x00500093 -> mem_addr sequence 0x0, 0x4, 0x8; instr 0x00500093 with instr_pc 0x0, valid one cycle after rvalid.
- instr_ready held low, FIFO_DEPTH = 2 -> exactly 2 grants, then mem_req stays low. Raise ready -> pops in PC order 0x0, 0x4; fetching resumes at 0x8.
- Redirect to 0x103 while in WAIT -> old response discarded, instr_valid low; next mem_addr 0x100; first delivered instr_pc 0x100.
- Redirect in the same cycle as mem_rvalid -> that word is never delivered; kill stays 0; next request at the redirect target.
- mem_req pending with mem_gnt low for 5 cycles, then redirect -> mem_addr unchanged until gnt; that response is discarded; the target is fetched next.
- mem_rdata = 0x00000000 -> instr_illegal = 1 with instr_valid. Fetch at 0xFFFF_FFFC -> next mem_addr 0x0000_0000.
